z_run_length_encoder: RTL and testbench

Z_RUN_LENGTH_ENCODER -- requirements
Module: z_run_length_encoder

---
 rtl/z_run_length_encoder.sv | 129 ++++++++++++
 tb/tb_z_run_length_encoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z_run_length_encoder.sv
// Run-length encoder for a sampled bit stream: closes runs into {value, length}
// records and queues them in a small FIFO with a sticky drop flag.
module z_run_length_encoder #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     z,
    input  logic                     in_en,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_value,
    output logic [CNT_W-1:0]         out_len,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow
);

    localparam int               AW     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] MAXLEN = '1;
    localparam logic [AW:0]      FULL   = (AW+1)'(DEPTH);

    logic             run_active_q, run_active_d;
    logic             run_val_q, run_val_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      occ_q, occ_d;
    logic             overflow_q;

    logic             val_mem_q [DEPTH];
    logic [CNT_W-1:0] len_mem_q [DEPTH];

    logic             push;
    logic             pop;
    logic             wr_en;
    logic             full;

    // Run tracking: decides whether this edge closes a run and what the new run looks like.
    always_comb begin
        run_active_d = run_active_q;
        run_val_d    = run_val_q;
        run_len_d    = run_len_q;
        push         = 1'b0;
        if (flush) begin
            push = run_active_q;
            if (in_en) begin
                run_active_d = 1'b1;
                run_val_d    = z;
                run_len_d    = CNT_W'(1);
            end else begin
                run_active_d = 1'b0;
            end
        end else if (in_en) begin
            if (!run_active_q) begin
                run_active_d = 1'b1;
                run_val_d    = z;
                run_len_d    = CNT_W'(1);
            end else if (z == run_val_q) begin
                if (run_len_q == MAXLEN) begin
                    // Saturated run is emitted and continues as a fresh run of the same value.
                    push      = 1'b1;
                    run_len_d = CNT_W'(1);
                end else begin
                    run_len_d = run_len_q + CNT_W'(1);
                end
            end else begin
                push      = 1'b1;
                run_val_d = z;
                run_len_d = CNT_W'(1);
            end
        end
    end

    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    always_comb begin
        full  = (occ_q == FULL);
        pop   = out_valid && out_ready;
        wr_en = push && (!full || pop);
        occ_d = occ_q;
        if (wr_en && !pop) begin
            occ_d = occ_q + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            occ_d = occ_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_active_q <= 1'b0;
            run_val_q    <= 1'b0;
            run_len_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            overflow_q   <= 1'b0;
        end else begin
            run_active_q <= run_active_d;
            run_val_q    <= run_val_d;
            run_len_q    <= run_len_d;
            occ_q        <= occ_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            val_mem_q[wr_ptr_q] <= run_val_q;
            len_mem_q[wr_ptr_q] <= (push && run_len_q == MAXLEN && in_en && !flush && z == run_val_q)
                                   ? MAXLEN : run_len_q;
        end
    end

    // Head fields are masked while empty so reset and idle both present zeros.
    assign out_valid = (occ_q != '0);
    assign out_value = out_valid & val_mem_q[rd_ptr_q];
    assign out_len   = out_valid ? len_mem_q[rd_ptr_q] : '0;
    assign occupancy = occ_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_z_run_length_encoder.sv
// Bench for z_run_length_encoder: directed vector table, corner sequences and
// randomized traffic checked against a queue-based run/FIFO model.
module tb_z_run_length_encoder;

    localparam int CNT_W  = 8;
    localparam int DEPTH  = 4;
    localparam int MAXLEN = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic z = 1'b0, in_en = 1'b0, flush = 1'b0, out_ready = 1'b0, out_ready_b = 1'b0;

    logic                   out_valid, out_value, overflow;
    logic [CNT_W-1:0]       out_len;
    logic [$clog2(DEPTH):0] occupancy;

    logic                   out_valid_b, out_value_b, overflow_b;
    logic [1:0]             out_len_b;
    logic [$clog2(DEPTH):0] occupancy_b;

    z_run_length_encoder #(.CNT_W(CNT_W), .DEPTH(DEPTH)) u_dut (
        .clock(clock), .reset(reset), .z(z), .in_en(in_en), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_len(out_len), .occupancy(occupancy), .overflow(overflow)
    );

    z_run_length_encoder #(.CNT_W(2), .DEPTH(4)) u_dut_b (
        .clock(clock), .reset(reset), .z(z), .in_en(in_en), .flush(flush),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_value(out_value_b),
        .out_len(out_len_b), .occupancy(occupancy_b), .overflow(overflow_b)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: records as {value, length} in a bounded queue.
    logic [CNT_W:0] exp_q[$];
    bit             m_active, m_val, m_ovf;
    int             m_len;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active = 1'b0;
        m_val    = 1'b0;
        m_len    = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_step(input bit zz, input bit en, input bit fl, input bit rdy);
        bit             have_push = 1'b0;
        logic [CNT_W:0] rec = '0;
        bit             was_full = (exp_q.size() == DEPTH);
        bit             do_pop = (exp_q.size() != 0) && rdy;
        if (fl) begin
            if (m_active) begin
                have_push = 1'b1;
                rec = {m_val, CNT_W'(m_len)};
            end
            if (en) begin
                m_active = 1'b1; m_val = zz; m_len = 1;
            end else begin
                m_active = 1'b0;
            end
        end else if (en) begin
            if (!m_active) begin
                m_active = 1'b1; m_val = zz; m_len = 1;
            end else if (zz == m_val) begin
                if (m_len == MAXLEN) begin
                    have_push = 1'b1;
                    rec = {m_val, CNT_W'(MAXLEN)};
                    m_len = 1;
                end else begin
                    m_len++;
                end
            end else begin
                have_push = 1'b1;
                rec = {m_val, CNT_W'(m_len)};
                m_val = zz; m_len = 1;
            end
        end
        if (do_pop) void'(exp_q.pop_front());
        if (have_push) begin
            if (!was_full || do_pop) exp_q.push_back(rec);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_model(input string name);
        logic [CNT_W:0] head;
        check({name, " valid"}, int'(out_valid), int'(exp_q.size() != 0));
        check({name, " occupancy"}, int'(occupancy), exp_q.size());
        check({name, " overflow"}, int'(overflow), int'(m_ovf));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check({name, " value"}, int'(out_value), int'(head[CNT_W]));
            check({name, " len"}, int'(out_len), int'(head[CNT_W-1:0]));
        end
    endtask

    // Called at a falling edge; drives inputs, takes one rising edge, compares, returns at next falling edge.
    task automatic step(input bit zz, input bit en, input bit fl, input bit rdy, input string name);
        z = zz; in_en = en; flush = fl; out_ready = rdy;
        @(posedge clock);
        model_step(zz, en, fl, rdy);
        #1;
        check_model(name);
        @(negedge clock);
    endtask

    task automatic check_zero(input string name);
        check({name, " valid"}, int'(out_valid), 0);
        check({name, " value"}, int'(out_value), 0);
        check({name, " len"}, int'(out_len), 0);
        check({name, " occupancy"}, int'(occupancy), 0);
        check({name, " overflow"}, int'(overflow), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; in_en = 1'b0; flush = 1'b0; out_ready = 1'b0; out_ready_b = 1'b0;
        #1;
        check_zero("reset");
        check("reset b occupancy", int'(occupancy_b), 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        bit z, en, fl, rdy;
        bit e_valid, e_value;
        int e_len, e_occ;
    } vec_t;

    vec_t vt[7];

    initial begin : watchdog
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        logic [2:0] exp_b [3];
        int flip_div, ovf_phase;
        bit zc;

        vt[0] = '{1,1,0,1, 0,0,0,0};
        vt[1] = '{1,1,0,1, 0,0,0,0};
        vt[2] = '{1,1,0,1, 0,0,0,0};
        vt[3] = '{0,1,0,1, 1,1,3,1};
        vt[4] = '{0,1,0,1, 0,0,0,0};
        vt[5] = '{0,0,1,1, 1,0,2,1};
        vt[6] = '{0,0,0,1, 0,0,0,0};

        model_reset();
        do_reset();

        // Basic encode/flush: records {1,3},{0,2}.
        for (int i = 0; i < 7; i++) begin
            step(vt[i].z, vt[i].en, vt[i].fl, vt[i].rdy, "vec");
            check($sformatf("vec%0d valid", i), int'(out_valid), int'(vt[i].e_valid));
            check($sformatf("vec%0d occ", i), int'(occupancy), vt[i].e_occ);
            if (vt[i].e_valid) begin
                check($sformatf("vec%0d value", i), int'(out_value), int'(vt[i].e_value));
                check($sformatf("vec%0d len", i), int'(out_len), vt[i].e_len);
            end
        end

        // Overflow: alternating samples with no consumer.
        do_reset();
        for (int i = 0; i < 6; i++) step((i % 2) == 0, 1, 0, 0, "ovf fill");
        check("ovf occ", int'(occupancy), 4);
        check("ovf flag", int'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf drain%0d value", i), int'(out_value), int'((i % 2) == 0));
            check($sformatf("ovf drain%0d len", i), int'(out_len), 1);
            step(0, 0, 0, 1, "ovf drain");
        end
        check("ovf drained occ", int'(occupancy), 0);
        check("ovf sticky", int'(overflow), 1);

        // Push and pop together while full.
        do_reset();
        for (int i = 0; i < 5; i++) step((i % 2) == 0, 1, 0, 0, "full fill");
        check("full occ", int'(occupancy), 4);
        step(0, 1, 0, 1, "full pushpop");
        check("full pushpop occ", int'(occupancy), 4);
        check("full pushpop ovf", int'(overflow), 0);
        check("full pushpop head value", int'(out_value), 0);
        check("full pushpop head len", int'(out_len), 1);

        // Flush with a concurrent equal-valued sample closes the run at 5.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, "flush5");
        step(1, 1, 1, 0, "flush5 en");
        check("flush5 occ", int'(occupancy), 1);
        check("flush5 len", int'(out_len), 5);
        check("flush5 value", int'(out_value), 1);
        step(0, 0, 1, 0, "flush5 close");
        step(0, 0, 0, 1, "flush5 pop");
        check("flush5 new run len", int'(out_len), 1);
        check("flush5 new run value", int'(out_value), 1);

        // Asynchronous reset with stored records and an open run.
        do_reset();
        step(1, 1, 0, 0, "arst"); step(0, 1, 0, 0, "arst");
        step(1, 1, 0, 0, "arst"); step(0, 1, 0, 0, "arst");
        check("arst pre occ", int'(occupancy), 3);
        #2;
        reset = 1'b1;
        #1;
        check_zero("arst mid");
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        step(0, 1, 0, 0, "arst post");
        step(0, 1, 0, 0, "arst post");
        step(0, 0, 1, 0, "arst post flush");
        check("arst rec occ", int'(occupancy), 1);
        check("arst rec value", int'(out_value), 0);
        check("arst rec len", int'(out_len), 2);
        step(0, 0, 0, 1, "arst post pop");
        check("arst no extra", int'(occupancy), 0);

        // Narrow counter saturation on the CNT_W=2 instance.
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 1, 0, 0, "sat");
        step(1, 0, 1, 0, "sat flush");
        check("sat b occ", int'(occupancy_b), 3);
        check("sat b ovf", int'(overflow_b), 0);
        exp_b[0] = 3'b111; exp_b[1] = 3'b111; exp_b[2] = 3'b101;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sat b rec%0d valid", i), int'(out_valid_b), 1);
            check($sformatf("sat b rec%0d value", i), int'(out_value_b), int'(exp_b[i][2]));
            check($sformatf("sat b rec%0d len", i), int'(out_len_b), int'(exp_b[i][1:0]));
            out_ready_b = 1'b1;
            @(posedge clock);
            @(negedge clock);
            out_ready_b = 1'b0;
        end
        check("sat b empty", int'(occupancy_b), 0);

        // Randomized traffic: phases alternate between busy short runs and long held runs.
        do_reset();
        zc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            flip_div  = ((c / 500) % 2 == 1) ? 600 : 3;
            ovf_phase = ((c / 250) % 3 == 2) ? 1 : 0;
            if ($urandom_range(0, flip_div - 1) == 0) zc = ~zc;
            step(zc,
                 (flip_div > 3) ? 1'b1 : ($urandom_range(0, 3) != 0),
                 (flip_div > 3) ? 1'b0 : ($urandom_range(0, 29) == 0),
                 ovf_phase ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 9) < 7),
                 "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
